// File: rtl/beam_sum_serializer_pkg.sv
// Shared types, sizing and the round/narrow helper for the beam-sum path.
// Define SUM_SAT_EN to saturate the narrowed value; otherwise it wraps.
package beam_sum_serializer_pkg;

    localparam int BEAM  = 16;
    localparam int OW    = 48;
    localparam int DW    = 16;
    localparam int SHIFT = 15;
    localparam int IW    = $clog2(BEAM);

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
    } sum_sample_t;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } out_sample_t;

    localparam logic signed [OW:0] RND_ADD = (OW+1)'(1) << (SHIFT-1);
    localparam logic signed [OW:0] SAT_MAX = (OW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [OW:0] SAT_MIN = -SAT_MAX - (OW+1)'(1);

    // One extra bit of headroom so the rounding add cannot overflow.
    function automatic logic [DW-1:0] round_narrow(input logic [OW-1:0] x);
        logic signed [OW:0] rounded;
        rounded = ($signed({x[OW-1], x}) + RND_ADD) >>> SHIFT;
`ifdef SUM_SAT_EN
        if (rounded > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (rounded < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end
        return rounded[DW-1:0];
`else
        return rounded[DW-1:0];
`endif
    endfunction

endpackage

// File: rtl/beam_sum_serializer_round.sv
// Combinational round-half-up and narrow of one real or imaginary component.
module beam_sum_round
    import beam_sum_serializer_pkg::*;
(
    input  logic [OW-1:0] sum,
    output logic [DW-1:0] rounded
);

    assign rounded = round_narrow(sum);

endmodule

// File: rtl/beam_sum_serializer.sv
// Two-entry vector buffer feeding a one-beam-per-beat ready/valid stream.
// Narrowing saturates when SUM_SAT_EN is defined, otherwise wraps.
module beam_sum_serializer
    import beam_sum_serializer_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [BEAM-1:0][2*OW-1:0]   i_sum_data,
    input  logic                        i_tvalid,
    output logic [2*DW-1:0]             o_tdata,
    output logic                        o_tvalid,
    input  logic                        i_tready,
    output logic                        o_tlast,
    output logic [IW-1:0]               o_tuser,
    output logic                        o_drop,
    output logic [15:0]                 o_drop_cnt
);

    logic [BEAM-1:0][2*OW-1:0] buf_mem [2];

    state_t          state_reg, state_next;
    logic [1:0]      cnt_reg, cnt_next;
    logic            wr_ptr_reg, wr_ptr_next;
    logic            ld_ptr_reg, ld_ptr_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            out_valid_reg, out_valid_next;
    logic [2*DW-1:0] out_data_reg, out_data_next;
    logic [IW-1:0]   out_user_reg, out_user_next;
    logic            out_last_reg, out_last_next;
    logic            drop_reg, drop_next;
    logic [15:0]     drop_cnt_reg, drop_cnt_next;

    logic            accept, free_last, load, last_idx, wr_ok, tail_next;
    logic [2*OW-1:0] head_beam;
    logic [DW-1:0]   re_rnd, im_rnd;

    assign head_beam = buf_mem[ld_ptr_reg][idx_reg];

    beam_sum_round u_round_re (.sum(head_beam[2*OW-1:OW]), .rounded(re_rnd));
    beam_sum_round u_round_im (.sum(head_beam[OW-1:0]),    .rounded(im_rnd));

    // An entry stays occupied until its last beat leaves the output register,
    // so a strobe coinciding with that acceptance can reuse the slot.
    assign accept    = out_valid_reg && i_tready;
    assign free_last = accept && out_last_reg;
    assign last_idx  = (idx_reg == IW'(BEAM-1));
    assign load      = (state_reg == SEND) && (!out_valid_reg || i_tready);
    assign wr_ok     = i_tvalid && ((cnt_reg != 2'd2) || free_last);

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            buf_mem[wr_ptr_reg] <= i_sum_data;
        end
    end

    always_comb begin
        cnt_next       = cnt_reg + 2'(wr_ok) - 2'(free_last);
        wr_ptr_next    = wr_ptr_reg ^ wr_ok;
        ld_ptr_next    = ld_ptr_reg;
        idx_next       = idx_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_user_next  = out_user_reg;
        out_last_next  = out_last_reg;
        drop_next      = i_tvalid && !wr_ok;
        drop_cnt_next  = drop_cnt_reg;

        if (drop_next && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_next = drop_cnt_reg + 16'd1;
        end

        if (load) begin
            out_valid_next = 1'b1;
            out_data_next  = {re_rnd, im_rnd};
            out_user_next  = idx_reg;
            out_last_next  = last_idx;
            idx_next       = last_idx ? '0 : idx_reg + IW'(1);
            ld_ptr_next    = ld_ptr_reg ^ last_idx;
        end else if (accept) begin
            out_valid_next = 1'b0;
        end

        // SEND while some occupied entry still has beats left to load.
        tail_next  = out_valid_next && out_last_next;
        state_next = (cnt_next != 2'(tail_next)) ? SEND : IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            wr_ptr_reg    <= 1'b0;
            ld_ptr_reg    <= 1'b0;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_user_reg  <= '0;
            out_last_reg  <= 1'b0;
            drop_reg      <= 1'b0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            wr_ptr_reg    <= wr_ptr_next;
            ld_ptr_reg    <= ld_ptr_next;
            idx_reg       <= idx_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_user_reg  <= out_user_next;
            out_last_reg  <= out_last_next;
            drop_reg      <= drop_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    assign o_tdata    = out_data_reg;
    assign o_tvalid   = out_valid_reg;
    assign o_tlast    = out_last_reg;
    assign o_tuser    = out_user_reg;
    assign o_drop     = drop_reg;
    assign o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_beam_sum_serializer.sv
// Scoreboard bench for beam_sum_serializer: directed vectors with hand-derived beats.
module tb_beam_sum_serializer;
    import beam_sum_serializer_pkg::*;

    typedef logic [BEAM-1:0][2*OW-1:0] vec_t;
    typedef struct packed {
        logic [2*DW-1:0] data;
        logic [IW-1:0]   user;
        logic            last;
    } beat_t;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    vec_t            i_sum_data = '0;
    logic            i_tvalid = 1'b0;
    logic            i_tready = 1'b0;
    logic [2*DW-1:0] o_tdata;
    logic            o_tvalid;
    logic            o_tlast;
    logic [IW-1:0]   o_tuser;
    logic            o_drop;
    logic [15:0]     o_drop_cnt;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    beam_sum_serializer dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sum_data (i_sum_data),
        .i_tvalid   (i_tvalid),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .i_tready   (i_tready),
        .o_tlast    (o_tlast),
        .o_tuser    (o_tuser),
        .o_drop     (o_drop),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // Stimulus patterns; each component is a signed 48-bit value.
    function automatic vec_t build(input int mode);
        vec_t v;
        longint re, im;
        for (int k = 0; k < BEAM; k++) begin
            re = 0;
            im = 0;
            case (mode)
                0: begin re = longint'(k) << 15;               im = -(longint'(k) << 15); end
                1: begin re = (longint'(k) << 15) + 16384;     im = -(longint'(k) << 15) - 16384; end
                2: begin re = longint'(3 * k) << 15;           im = (longint'(k) << 15) + 16383; end
                default: begin
                    case (k)
                        0: begin re = 16384;                    im = -16384; end
                        1: begin re = longint'(1) << 40;        im = -(longint'(1) << 40); end
                        2: begin re = 16383;                    im = -16385; end
                        3: begin re = -(longint'(5) << 15) - 16384; im = longint'(32767) << 15; end
                        4: begin re = (longint'(32767) << 15) + 16384; im = -(longint'(32768) << 15) - 16384; end
                        default: begin re = 0; im = 0; end
                    endcase
                end
            endcase
            v[k] = {OW'(re), OW'(im)};
        end
        return v;
    endfunction

    // Hand-derived {re, im} after round-half-up and narrowing.
    function automatic logic [2*DW-1:0] exp_beat(input int mode, input int k);
        logic [DW-1:0] re, im;
        re = '0;
        im = '0;
        case (mode)
            0: begin re = DW'(k);     im = DW'(-k); end
            1: begin re = DW'(k + 1); im = DW'(-k); end
            2: begin re = DW'(3 * k); im = DW'(k);  end
            default: begin
                case (k)
                    0: begin re = 16'h0001; im = 16'h0000; end
`ifdef SUM_SAT_EN
                    1: begin re = 16'h7FFF; im = 16'h8000; end
                    4: begin re = 16'h7FFF; im = 16'h8000; end
`else
                    1: begin re = 16'h0000; im = 16'h0000; end
                    4: begin re = 16'h8000; im = 16'h8000; end
`endif
                    2: begin re = 16'h0000; im = 16'hFFFF; end
                    3: begin re = 16'hFFFB; im = 16'h7FFF; end
                    default: begin re = '0; im = '0; end
                endcase
            end
        endcase
        return {re, im};
    endfunction

    task automatic push_vec(input int mode);
        beat_t b;
        for (int k = 0; k < BEAM; k++) begin
            b.data = exp_beat(mode, k);
            b.user = IW'(k);
            b.last = (k == BEAM - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic strobe(input int mode, input bit keep, output logic drop);
        @(posedge i_clk); #1;
        i_sum_data = build(mode);
        i_tvalid   = 1'b1;
        if (keep) push_vec(mode);
        @(posedge i_clk); #1;
        i_tvalid = 1'b0;
        drop     = o_drop;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    // Monitor: pops one expected beat per transfer, checks stall stability.
    initial begin
        beat_t           e;
        logic            hold_valid;
        logic [2*DW-1:0] hold_data;
        hold_valid = 1'b0;
        hold_data  = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) begin
                    check("stall_hold", {o_tvalid, o_tdata}, {1'b1, hold_data});
                end
                hold_valid = o_tvalid && !i_tready;
                hold_data  = o_tdata;
                if (o_tvalid && i_tready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL beat: got unexpected beat %0h user %0d, expected none", o_tdata, o_tuser);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat u%0d", e.user), {o_tdata, o_tuser, o_tlast}, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic drop;
        bit   found;

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_outputs", {o_tvalid, o_tdata, o_tuser, o_tlast, o_drop, o_drop_cnt}, 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Single ramp vector with latency check.
        i_tready = 1'b1;
        strobe(0, 1'b1, drop);
        check("t1_no_drop", 64'(drop), 64'd0);
        check("t1_valid_n1", 64'(o_tvalid), 64'd0);
        @(posedge i_clk); #1;
        check("t1_valid_n2", {o_tvalid, o_tuser}, {1'b1, IW'(0)});
        wait_drain("t1_drain", 40);

        // Toggling ready.
        strobe(1, 1'b1, drop);
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge i_clk); #1;
            i_tready = ~i_tready;
        end
        i_tready = 1'b1;
        wait_drain("t2_drain", 10);

        // Backpressure overflow: third vector discarded.
        i_tready = 1'b0;
        strobe(0, 1'b1, drop);
        check("t3_a_no_drop", 64'(drop), 64'd0);
        repeat (18) @(posedge i_clk);
        strobe(2, 1'b1, drop);
        check("t3_b_no_drop", 64'(drop), 64'd0);
        repeat (18) @(posedge i_clk);
        strobe(1, 1'b0, drop);
        check("t3_c_drop", 64'(drop), 64'd1);
        @(posedge i_clk); #1;
        check("t3_drop_pulse_cnt", {o_drop, o_drop_cnt}, {1'b0, 16'd1});
        i_tready = 1'b1;
        wait_drain("t3_drain", 80);

        // Rounding and narrowing corner values.
        strobe(3, 1'b1, drop);
        wait_drain("t4_drain", 40);

        // Full buffer; strobe lands on the head's final accepted beat.
        i_tready = 1'b0;
        strobe(0, 1'b1, drop);
        strobe(1, 1'b1, drop);
        @(posedge i_clk); #1;
        i_tready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge i_clk);
            if (o_tvalid && o_tlast) found = 1'b1;
        end
        check("t5_found_last", 64'(found), 64'd1);
        i_sum_data = build(2);
        i_tvalid   = 1'b1;
        push_vec(2);
        @(posedge i_clk); #1;
        i_tvalid = 1'b0;
        check("t5_reuse_no_drop", {o_drop, o_drop_cnt}, {1'b0, 16'd1});
        wait_drain("t5_drain", 80);

        // Asynchronous reset during beat 5.
        strobe(2, 1'b1, drop);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge i_clk);
            if (o_tvalid && o_tuser == IW'(5)) found = 1'b1;
        end
        check("t6_found_beat5", 64'(found), 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", {o_tvalid, o_tdata, o_tuser, o_tlast, o_drop, o_drop_cnt}, 64'd0);
        exp_q.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check("t6_idle_after_reset", 64'(o_tvalid), 64'd0);
        end
        strobe(1, 1'b1, drop);
        wait_drain("t6_drain", 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/beam_sum_serializer.md
# beam_sum_serializer

Takes the parallel per-beam complex sums from the beamforming MAC stage and emits them as a ready/valid stream, one beam per beat. Each 2*OW-bit beam sum is rounded and narrowed to 2*DW bits on the way out. A two-entry vector buffer absorbs downstream backpressure. This block sits between the beam MAC array and the per-beam compression/packing stage of the PUSCH dimension-reduction path.

## Interface
- BEAM, 16, beams per input vector
- OW, 48, width of each real/imag component on input
- DW, 16, width of each real/imag component on output
- SHIFT, 15, LSBs dropped per component before narrowing (1 ≤ SHIFT < OW-DW+1)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_sum_data  in  [BEAM-1:0][2*OW-1:0]  per-beam sums, {re, im}, two's complement
- i_tvalid  in  1  single-cycle strobe; i_sum_data is valid this cycle
- o_tdata  out  2*DW  {re, im} of the current beam
- o_tvalid  out  1  o_tdata valid
- i_tready  in  1  downstream accepts the beat
- o_tlast  out  1  beat carries beam BEAM-1
- o_tuser  out  $clog2(BEAM)  beam index of the beat
- o_drop  out  1  one-cycle pulse when an input vector is discarded
- o_drop_cnt  out  16  saturating count of discarded vectors

## Operation
- The buffer holds 2 entries, each one full BEAM-wide vector. Write and read pointers are 1 bit and wrap.
- On i_tvalid with a free entry, the whole vector is captured at that edge.
- On i_tvalid with both entries occupied, the vector is discarded, o_drop pulses for one cycle, and o_drop_cnt increments, saturating at 0xFFFF.
- If the final beat of the head entry is accepted in the same cycle that i_tvalid arrives with the buffer full, the freed entry is reused and nothing is dropped.
- Read FSM states:
  - IDLE: buffer empty, o_tvalid=0.
  - SEND: beat index runs from 0 to BEAM-1 over the head entry.
- FSM transitions:
  - IDLE→SEND when an entry becomes occupied.
  - In SEND, an accepted beat at index BEAM-1 frees the entry, resets the index to 0, and stays in SEND if another entry is occupied; otherwise it goes to IDLE.
- A beat is transferred when o_tvalid && i_tready. o_tdata, o_tuser and o_tlast stay stable while o_tvalid && !i_tready.
- Per-component scaling, applied to re and im independently:
  - Add 2^(SHIFT-1), then arithmetic-shift right by SHIFT. This is round-half-up.
  - Narrow to DW bits; the narrowing rule is set under Configuration.
- o_tuser equals the beat index. o_tlast = (index == BEAM-1).
- Reset: all outputs 0, buffer empty, FSM in IDLE, o_drop_cnt=0. Reset asserted mid-vector aborts that vector with no o_tlast emitted; buffered data is lost.

## Timing
- i_tvalid at cycle N gives o_tvalid=1 with beam 0 at cycle N+2 when the buffer was empty.
- One buffer-write register and one output register; scaling sits between them.
- With i_tready held high, output rate is one beat per cycle. Back-to-back vectors stream with no bubble between beam BEAM-1 and the next beam 0.
- Sustained input is allowed at one vector per BEAM cycles; a faster input rate eventually drops vectors.
- o_drop asserts in cycle N+1 for a discarded strobe at N.

## Configuration
- SUM_SAT_EN defined: the rounded value is saturated to [-2^(DW-1), 2^(DW-1)-1].
- SUM_SAT_EN undefined: the rounded value is truncated to its low DW bits (wraps).

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, SEND);
  - the complex sample typedef {re, im} parameterised by width;
  - the round/saturate function, so the compression stage can reuse it.
- One sub-module: beam_sum_round, a single component's round plus narrow. It is combinational and instantiated twice (re and im).

## Test plan
- Single vector, i_tready=1; beam k has re=k·2^15, im=-k·2^15 → beams k=0..15 out with re=k, im=-k, o_tuser=k; beam 0 at N+2; o_tlast only on beat 15.
- i_tready toggles 1,0,1,0… → exactly 16 transfers, in order; o_tdata is unchanged across every stalled cycle.
- i_tready=0 and three strobes 20 cycles apart → third vector dropped, one o_drop pulse, o_drop_cnt=1. Releasing i_tready then yields 32 beats, with tlast on beats 16 and 32.
- Rounding: re=2^14 → 1; re=-2^14 → 0; re=2^40 → 0x7FFF with SUM_SAT_EN, 0x0000 without.
- Buffer full; final beat of the head accepted in the same cycle a new strobe arrives → o_drop stays 0 and 32 beats follow.
- i_rst_n pulled low during beat 5 → all outputs 0 immediately. After release, o_tvalid stays 0 until the next strobe, which then streams a full 16 beats.
